fetch_unit: RTL and testbench

//   Parametrised instruction-fetch front end for the RV32I core: owns the PC, drives the

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, imem request/ack handshake,
// prefetch FIFO of {instr, pc} and redirect flush/drain.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [31:0]                instr,
    output logic [XLEN-1:0]            instr_pc,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            req_q, req_d;
    logic [LW-1:0]   level_q, level_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;

    logic [31:0]     mem_w  [DEPTH];
    logic [XLEN-1:0] mem_pc [DEPTH];

    logic            fire;
    logic            pop;
    logic            pop_eff;
    logic            push;
    logic            flush;
    logic [XLEN-1:0] rtgt;

    assign rtgt    = redirect_pc & ~XLEN'(3);
    assign fire    = req_q & imem_ack;
    assign pop     = (level_q != '0) & instr_ready;
    assign flush   = redirect_valid;
    assign pop_eff = pop & ~flush;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        push    = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    // pending request without ack must be drained first
                    if (req_q && !imem_ack) begin
                        state_d = DRAIN;
                        tgt_d   = rtgt;
                    end else begin
                        pc_d = rtgt;
                    end
                end else if (fire) begin
                    push = 1'b1;
                    pc_d = pc_q + XLEN'(4);
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    tgt_d = rtgt;
                end
                if (fire) begin
                    state_d = FETCH;
                    pc_d    = redirect_valid ? rtgt : tgt_q;
                end
            end
            default: state_d = FETCH;
        endcase

        if (flush) begin
            level_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            level_d = level_q + LW'(push) - LW'(pop_eff);
            rd_d    = rd_q + AW'(pop_eff);
            wr_d    = wr_q + AW'(push);
        end

        req_d = (state_d == DRAIN) || (level_d < FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            req_q   <= 1'b0;
            level_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            req_q   <= req_d;
            level_q <= level_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_w[wr_q]  <= imem_rdata;
            mem_pc[wr_q] <= pc_q;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = (level_q != '0);
    assign instr       = mem_w[rd_q];
    assign instr_pc    = mem_pc[rd_q];
    assign fifo_level  = level_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        imem_req, imem_ack, redirect_valid;
    logic        instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc;
    logic [31:0] instr, instr_pc;
    logic [2:0]  fifo_level;

    logic        w_req, w_ack, w_redir, w_valid;
    logic [31:0] w_addr, w_rpc, w_instr, w_pc;
    logic [2:0]  w_level;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .fifo_level(fifo_level)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(32'h0),
        .redirect_valid(w_redir), .redirect_pc(w_rpc),
        .instr_valid(w_valid), .instr_ready(1'b1),
        .instr(w_instr), .instr_pc(w_pc), .fifo_level(w_level)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc, m_tgt;
    bit          m_drain, m_req;

    task automatic model_reset();
        q.delete();
        m_pc    = 32'h0;
        m_tgt   = 32'h0;
        m_drain = 1'b0;
        m_req   = 1'b0;
    endtask

    task automatic model_step();
        bit          fire, pop;
        logic [31:0] t;
        ent_t        e;
        fire = m_req && imem_ack;
        pop  = (q.size() != 0) && instr_ready;
        t    = redirect_pc & 32'hFFFF_FFFC;
        if (redirect_valid) begin
            q.delete();
            if (m_drain) begin
                m_tgt = t;
                if (fire) begin
                    m_pc    = t;
                    m_drain = 1'b0;
                end
            end else if (m_req && !imem_ack) begin
                m_drain = 1'b1;
                m_tgt   = t;
            end else begin
                m_pc = t;
            end
        end else if (m_drain) begin
            if (fire) begin
                m_pc    = m_tgt;
                m_drain = 1'b0;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (fire) begin
                e.w  = imem_rdata;
                e.pc = m_pc;
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        m_req = m_drain || (q.size() < DEPTH);
    endtask

    task automatic compare();
        check("req", 64'(imem_req), 64'(m_req));
        check("addr", 64'(imem_addr), 64'(m_pc));
        check("valid", 64'(instr_valid), 64'(q.size() != 0));
        check("level", 64'(fifo_level), 64'(q.size()));
        if (q.size() != 0) begin
            check("instr", 64'(instr), 64'(q[0].w));
            check("ipc", 64'(instr_pc), 64'(q[0].pc));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        rst = 1'b0;
        model_reset();
        compare();
    endtask

    initial begin
        idle_inputs();
        w_ack   = 1'b0;
        w_redir = 1'b0;
        w_rpc   = 32'h0;
        apply_reset();

        // stream at full rate; wrap instance runs alongside
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        w_ack       = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [31:0] e;
            imem_rdata = imem_addr ^ 32'hA5A5_0000;
            step();
            if (k == 1) begin
                check("t1_first", 64'(instr_valid), 64'd0);
            end else begin
                check("t1_valid", 64'(instr_valid), 64'd1);
                check("t1_pc", 64'(instr_pc), 64'(4 * (k - 2)));
                check("t1_instr", 64'(instr),
                      64'(32'(4 * (k - 2)) ^ 32'hA5A5_0000));
            end
            if (k <= 3) begin
                e = WRAP_PC + 32'(4 * (k - 1));
                check("t5_addr", 64'(w_addr), 64'(e));
                check("t5_req", 64'(w_req), 64'd1);
            end
        end
        w_redir = 1'b1;
        w_rpc   = 32'h0000_0103;
        @(posedge clk);
        @(negedge clk);
        w_redir = 1'b0;
        w_ack   = 1'b0;
        check("t5_redir", 64'(w_addr), 64'h100);
        check("t5_flush", 64'(w_valid), 64'd0);

        // fill to full with consumer stalled
        apply_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            imem_rdata = $urandom;
            step();
        end
        check("t2_level", 64'(fifo_level), 64'd4);
        check("t2_req", 64'(imem_req), 64'd0);
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_pc", 64'(instr_pc), 64'(4 * i));
            imem_rdata = $urandom;
            step();
            if (i == 0) begin
                check("t2_resume_req", 64'(imem_req), 64'd1);
                check("t2_resume_addr", 64'(imem_addr), 64'h10);
            end
        end

        // redirect during a slow request
        apply_reset();
        instr_ready = 1'b1;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("t3_hold_addr", 64'(imem_addr), 64'h0);
            check("t3_hold_req", 64'(imem_req), 64'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        check("t3_addr", 64'(imem_addr), 64'h100);
        check("t3_drop", 64'(fifo_level), 64'd0);
        imem_rdata = 32'h1234_5678;
        step();
        check("t3_pc", 64'(instr_pc), 64'h100);
        check("t3_valid", 64'(instr_valid), 64'd1);

        // redirect coincident with ack and pop
        apply_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            imem_rdata = $urandom;
            step();
        end
        check("t4_pre", 64'(fifo_level), 64'd2);
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("t4_level", 64'(fifo_level), 64'd0);
        check("t4_valid", 64'(instr_valid), 64'd0);
        check("t4_addr", 64'(imem_addr), 64'h40);
        step();
        check("t4_pc", 64'(instr_pc), 64'h40);

        // async reset mid-request
        apply_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imem_rdata = $urandom;
            step();
        end
        check("t6_pre", 64'(fifo_level), 64'd3);
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_req", 64'(imem_req), 64'd0);
        check("t6_valid", 64'(instr_valid), 64'd0);
        check("t6_level", 64'(fifo_level), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare();
        imem_ack = 1'b1;
        step();
        check("t6_addr", 64'(imem_addr), 64'h0);

        // random traffic
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            imem_ack       = ($urandom_range(0, 2) != 0);
            imem_rdata     = $urandom;
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom & 32'h0000_0FFF;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
